// File: rtl/shift_count_reg.sv
// shift_count_reg: WIDTH-bit working register with load, load-x2, increment,
// decrement (single cycle) and shift-left / shift-right / rotate-left by a
// variable amount (one bit per clock), start/busy/done handshake, carry flag
// and combinational parity.
//
// Optional build macro: SHIFT_COUNT_REG_SAT_EN -- when defined, INC and DEC
// saturate at all-ones / zero instead of wrapping.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   data_in  load operand
//   op       operation code, sampled on an accepted start
//   start    request, accepted on a clock edge while busy=0
//   amount   shift/rotate count, sampled on an accepted start
//   data_out register contents
//   busy     high while a multi-cycle shift is in progress
//   done     one-cycle pulse after every accepted operation completes
//   carry    bit lost / wrap indication of the last operation
//   parity   XOR of all data_out bits (combinational)

module shift_count_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic [SHW-1:0]   amount,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             parity
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [2:0] OP_HOLD    = 3'b000;
  localparam logic [2:0] OP_LOAD    = 3'b001;
  localparam logic [2:0] OP_LOAD_X2 = 3'b010;
  localparam logic [2:0] OP_INC     = 3'b011;
  localparam logic [2:0] OP_DEC     = 3'b100;
  localparam logic [2:0] OP_SHL     = 3'b101;
  localparam logic [2:0] OP_SHR     = 3'b110;
  localparam logic [2:0] OP_ROL     = 3'b111;

  logic [0:0]       state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [2:0]       sop_q, sop_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sop_q   <= OP_HOLD;
      data_q  <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sop_q   <= sop_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, datapath and handshake decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sop_d   = sop_q;
    data_d  = data_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    busy_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d = 1'b1;
          case (op)
            OP_HOLD: ;
            OP_LOAD: begin
              data_d  = data_in;
              carry_d = 1'b0;
            end
            OP_LOAD_X2: begin
              data_d  = {data_in[WIDTH-2:0], 1'b0};
              carry_d = data_in[WIDTH-1];
            end
            OP_INC: begin
              carry_d = &data_q;
`ifdef SHIFT_COUNT_REG_SAT_EN
              if (!(&data_q)) data_d = data_q + WIDTH'(1);
`else
              data_d = data_q + WIDTH'(1);
`endif
            end
            OP_DEC: begin
              carry_d = ~|data_q;
`ifdef SHIFT_COUNT_REG_SAT_EN
              if (|data_q) data_d = data_q - WIDTH'(1);
`else
              data_d = data_q - WIDTH'(1);
`endif
            end
            OP_SHL, OP_SHR, OP_ROL: begin
              // A zero count completes immediately as a HOLD
              if (amount != '0) begin
                done_d  = 1'b0;
                state_d = ST_SHIFT;
                cnt_d   = amount;
                sop_d   = op;
              end
            end
          endcase
        end
      end
      ST_SHIFT: begin
        // One bit per edge; carry takes the bit leaving the register
        case (sop_q)
          OP_SHR: begin
            data_d  = {1'b0, data_q[WIDTH-1:1]};
            carry_d = data_q[0];
          end
          OP_ROL: begin
            data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            carry_d = data_q[WIDTH-1];
          end
          default: begin
            data_d  = {data_q[WIDTH-2:0], 1'b0};
            carry_d = data_q[WIDTH-1];
          end
        endcase
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase

    busy_d = (state_d == ST_SHIFT);
  end

  assign data_out = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign carry    = carry_q;
  assign parity   = ^data_q;

endmodule

// File: tb/tb_shift_count_reg.sv
// Self-checking bench for shift_count_reg: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.

module tb_shift_count_reg;

  localparam int unsigned W  = 8;
  localparam int unsigned SH = 3;

`ifdef SHIFT_COUNT_REG_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, LDX2 = 3'd2, INC = 3'd3;
  localparam logic [2:0] DEC  = 3'd4, SHL  = 3'd5, SHR  = 3'd6, ROL = 3'd7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  data_in = '0;
  logic [2:0]    op = '0;
  logic          start = 1'b0;
  logic [SH-1:0] amount = '0;
  logic [W-1:0]  data_out;
  logic          busy, done, carry, parity;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [W-1:0] m_data  = '0;
  logic         m_carry = 1'b0;
  logic         m_done  = 1'b0;
  int           m_left  = 0;
  logic [2:0]   m_op    = HOLD;

  shift_count_reg #(.WIDTH(W), .SHW(SH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .op(op), .start(start),
    .amount(amount), .data_out(data_out), .busy(busy), .done(done),
    .carry(carry), .parity(parity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    m_data = '0; m_carry = 1'b0; m_done = 1'b0; m_left = 0; m_op = HOLD;
  endtask

  // One clock edge of behaviour: either one pending shift step, or a new request
  task automatic model_edge();
    int v;
    m_done = 1'b0;
    if (m_left > 0) begin
      case (m_op)
        SHR: begin m_carry = m_data[0]; m_data = m_data >> 1; end
        ROL: begin m_carry = m_data[W-1]; m_data = (m_data << 1) | (m_data >> (W-1)); end
        default: begin m_carry = m_data[W-1]; m_data = m_data << 1; end
      endcase
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (start) begin
      m_done = 1'b1;
      v = int'(m_data);
      case (op)
        LOAD: begin m_data = data_in; m_carry = 1'b0; end
        LDX2: begin m_carry = data_in[W-1]; m_data = data_in << 1; end
        INC: begin
          m_carry = (v == 255);
          if (!(SAT && m_carry)) m_data = W'((v + 1) % 256);
        end
        DEC: begin
          m_carry = (v == 0);
          if (!(SAT && m_carry)) m_data = W'((v + 255) % 256);
        end
        SHL, SHR, ROL: begin
          if (amount != 0) begin
            m_left = int'(amount);
            m_op   = op;
            m_done = 1'b0;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("data_out", 32'(data_out), 32'(m_data));
    chk("busy",     32'(busy),     32'(m_left > 0));
    chk("done",     32'(done),     32'(m_done));
    chk("carry",    32'(carry),    32'(m_carry));
    chk("parity",   32'(parity),   32'($countones(m_data) % 2));
  endtask

  // Drive inputs, clock once, advance model, check outputs on the falling edge
  task automatic tick(input logic s, input logic [2:0] o, input logic [SH-1:0] a,
                      input logic [W-1:0] d);
    start = s; op = o; amount = a; data_in = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset pulse between clock edges
  task automatic async_reset(input bit literal_checks);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    if (literal_checks) begin
      chk("rst_data",  32'(data_out), 32'h00);
      chk("rst_busy",  32'(busy),     32'h0);
      chk("rst_carry", 32'(carry),    32'h0);
      chk("rst_done",  32'(done),     32'h0);
    end
    #1 rst = 1'b0;
  endtask

  initial begin
    // Power-on reset
    #3;
    chk("por_data",  32'(data_out), 32'h00);
    chk("por_busy",  32'(busy),     32'h0);
    chk("por_done",  32'(done),     32'h0);
    chk("por_carry", 32'(carry),    32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a shift, then normal operation
    tick(1, LOAD, 0, 8'h81);
    tick(1, SHL, 5, 8'h00);
    tick(0, HOLD, 0, 8'h00);
    tick(0, HOLD, 0, 8'h00);
    chk("shl5_step2", 32'(data_out), 32'h04);
    chk("shl5_busy",  32'(busy),     32'h1);
    async_reset(1);
    tick(1, LOAD, 0, 8'h3C);
    chk("post_rst_load", 32'(data_out), 32'h3C);
    chk("post_rst_done", 32'(done),     32'h1);
    tick(0, HOLD, 0, 8'h00);
    chk("done_one_cycle", 32'(done), 32'h0);

    // Loads and parity
    tick(1, LOAD, 0, 8'hA5);
    chk("model_pin_a5", 32'(m_data), 32'hA5);
    chk("load_a5",   32'(data_out), 32'hA5);
    chk("parity_a5", 32'(parity),   32'h0);
    chk("load_done", 32'(done),     32'h1);
    tick(1, LDX2, 0, 8'hC3);
    chk("ldx2_data",   32'(data_out), 32'h86);
    chk("ldx2_carry",  32'(carry),    32'h1);
    chk("ldx2_parity", 32'(parity),   32'h1);

    // Wrap / saturate
    tick(1, LOAD, 0, 8'hFF);
    tick(1, INC, 0, 8'h00);
    chk("inc_ff", 32'(data_out), SAT ? 32'hFF : 32'h00);
    chk("inc_ff_carry", 32'(carry), 32'h1);
    tick(1, LOAD, 0, 8'h00);
    tick(1, DEC, 0, 8'h00);
    chk("dec_00", 32'(data_out), SAT ? 32'h00 : 32'hFF);
    chk("dec_00_carry", 32'(carry), 32'h1);
    tick(1, LOAD, 0, 8'h41);
    tick(1, INC, 0, 8'h00);
    chk("model_pin_42", 32'(m_data), 32'h42);
    chk("inc_41", 32'(data_out), 32'h42);
    chk("inc_41_carry", 32'(carry), 32'h0);

    // Multi-cycle SHL by 3
    tick(1, LOAD, 0, 8'h81);
    tick(1, SHL, 3, 8'h00);
    chk("shl3_e0_busy", 32'(busy), 32'h1);
    chk("shl3_e0_data", 32'(data_out), 32'h81);
    tick(0, HOLD, 0, 8'h00);
    chk("shl3_s1", 32'(data_out), 32'h02);
    tick(0, HOLD, 0, 8'h00);
    chk("shl3_s2", 32'(data_out), 32'h04);
    chk("shl3_s2_busy", 32'(busy), 32'h1);
    tick(0, HOLD, 0, 8'h00);
    chk("shl3_s3", 32'(data_out), 32'h08);
    chk("shl3_carry", 32'(carry), 32'h0);
    chk("shl3_done", 32'(done), 32'h1);
    chk("shl3_busy_end", 32'(busy), 32'h0);

    // Rotate / shift right / zero count
    tick(1, LOAD, 0, 8'h81);
    tick(1, ROL, 1, 8'h00);
    tick(0, HOLD, 0, 8'h00);
    chk("rol1", 32'(data_out), 32'h03);
    chk("rol1_carry", 32'(carry), 32'h1);
    tick(1, LOAD, 0, 8'h81);
    tick(1, SHR, 1, 8'h00);
    tick(0, HOLD, 0, 8'h00);
    chk("shr1", 32'(data_out), 32'h40);
    chk("shr1_carry", 32'(carry), 32'h1);
    tick(1, LOAD, 0, 8'h81);
    tick(1, SHL, 0, 8'h00);
    chk("shl0_data", 32'(data_out), 32'h81);
    chk("shl0_busy", 32'(busy), 32'h0);
    chk("shl0_done", 32'(done), 32'h1);

    // Start while busy is ignored; start in the done cycle is accepted
    tick(1, LOAD, 0, 8'hF0);
    tick(1, SHR, 4, 8'h00);
    tick(1, LOAD, 0, 8'h55);
    tick(1, LOAD, 0, 8'h55);
    tick(1, LOAD, 0, 8'h55);
    tick(0, HOLD, 0, 8'h00);
    chk("shr4_data", 32'(data_out), 32'h0F);
    chk("shr4_done", 32'(done), 32'h1);
    tick(1, LOAD, 0, 8'h55);
    chk("load_in_done", 32'(data_out), 32'h55);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0)
        async_reset(0);
      tick(($urandom_range(0, 9) < 6), 3'($urandom), SH'($urandom), W'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
